// File: rtl/sparse_chunk_pingpong_buf_pkg.sv
//============================================================================
// Module : sparse_chunk_pingpong_buf_pkg
// Brief  : Shared types and sizing helpers for the multi-bank sparse chunk buffer.
// Rev    : 1.0
//============================================================================
`default_nettype none

package sparse_chunk_pingpong_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    function automatic int beats(input int mem_w, input int bus_w);
        return mem_w / bus_w;
    endfunction

    function automatic int cnt_w(input int mem_w);
        return $clog2(mem_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sparse_chunk_pingpong_buf_if.sv
//============================================================================
// Module : sparse_chunk_pingpong_buf_if
// Brief  : Write-beat and head-chunk read bundle of the sparse chunk buffer.
// Rev    : 1.0
//============================================================================
`default_nettype none

interface sparse_chunk_pingpong_buf_if
    import sparse_chunk_pingpong_buf_pkg::*;
#(
    parameter int BUS_W     = 128,
    parameter int MEM_W     = 512,
    parameter int NUM_BANKS = 2,
    parameter int DAT_W     = 8
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = cnt_w(MEM_W);

    logic                            flush_i;
    logic                            wr_valid_i;
    logic                            wr_ready_o;
    logic [BUS_W-1:0]                wr_sparsemap_i;
    logic [BUS_W-1:0][DAT_W-1:0]     wr_nonzero_data_i;
    logic                            rd_valid_o;
    logic                            rd_release_i;
    logic [BANK_W-1:0]               rd_bank_o;
    logic [MEM_W-1:0]                rd_sparsemap_o;
    logic [MEM_W:1][DAT_W-1:0]       rd_nonzero_data_o;
    logic [CNT_W-1:0]                rd_nz_cnt_o;

    modport master (
        output flush_i, wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, rd_release_i,
        input  wr_ready_o, rd_valid_o, rd_bank_o, rd_sparsemap_o, rd_nonzero_data_o, rd_nz_cnt_o
    );

    modport slave (
        input  flush_i, wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, rd_release_i,
        output wr_ready_o, rd_valid_o, rd_bank_o, rd_sparsemap_o, rd_nonzero_data_o, rd_nz_cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/sparse_chunk_pingpong_buf_popcount.sv
//============================================================================
// Module : chunk_popcount
// Brief  : Combinational population count of one sparsemap beat.
// Rev    : 1.0
//============================================================================
`default_nettype none

module chunk_popcount #(
    parameter int BUS_W = 128,
    localparam int OUT_W = $clog2(BUS_W + 1)
) (
    input  logic [BUS_W-1:0] i_bits,
    output logic [OUT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < BUS_W; i++) begin
            o_count = o_count + OUT_W'(i_bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sparse_chunk_pingpong_buf.sv
//============================================================================
// Module : sparse_chunk_pingpong_buf
// Brief  : Multi-bank store of compressed chunks between DMA fill and PE fetch.
// Rev    : 1.0
//============================================================================
`default_nettype none

module sparse_chunk_pingpong_buf
    import sparse_chunk_pingpong_buf_pkg::*;
#(
    parameter int BUS_W     = 128,
    parameter int MEM_W     = 512,
    parameter int NUM_BANKS = 2,
    parameter int DAT_W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    sparse_chunk_pingpong_buf_if.slave bus
);

    localparam int BEATS  = beats(MEM_W, BUS_W);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int CNT_W  = cnt_w(MEM_W);
    localparam int PC_W   = $clog2(BUS_W + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    bank_state_e                r_state [NUM_BANKS];
    logic [BANK_W-1:0]          r_wr_ptr;
    logic [BANK_W-1:0]          r_rd_ptr;
    logic [BEAT_W-1:0]          r_beat_cnt;

    logic                       w_wr_ready;
    logic                       w_accept;
    logic                       w_release;
    logic                       w_last_beat;
    logic [31:0]                w_base;
    logic [PC_W-1:0]            w_popcnt;
    logic [MEM_W-1:0]           w_map  [NUM_BANKS];
    logic [MEM_W:1][DAT_W-1:0]  w_data [NUM_BANKS];
    logic [CNT_W-1:0]           w_cnt  [NUM_BANKS];

    // A FULL bank under the write pointer means every bank is waiting on the reader.
    assign w_wr_ready  = (r_state[r_wr_ptr] != FULL);
    assign w_accept    = bus.wr_valid_i && w_wr_ready && !bus.flush_i;
    assign w_release   = bus.rd_release_i && (r_state[r_rd_ptr] == FULL) && !bus.flush_i;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_base      = BUS_W * 32'(r_beat_cnt);

    chunk_popcount #(
        .BUS_W (BUS_W)
    ) u_popcount (
        .i_bits  (bus.wr_sparsemap_i),
        .o_count (w_popcnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BANKS; b++) r_state[b] <= EMPTY;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (bus.flush_i) begin
            for (int b = 0; b < NUM_BANKS; b++) r_state[b] <= EMPTY;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            // Release and accept always target different banks: one needs FULL, the other not.
            if (w_release) begin
                r_state[r_rd_ptr] <= EMPTY;
                r_rd_ptr          <= r_rd_ptr + BANK_W'(1);
            end
            if (w_accept) begin
                if (w_last_beat) begin
                    r_state[r_wr_ptr] <= FULL;
                    r_beat_cnt        <= '0;
                    r_wr_ptr          <= r_wr_ptr + BANK_W'(1);
                end else begin
                    r_state[r_wr_ptr] <= FILLING;
                    r_beat_cnt        <= r_beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic                      w_we;
            logic [MEM_W-1:0]          r_map;
            logic [MEM_W:1][DAT_W-1:0] r_data;
            logic [CNT_W-1:0]          r_cnt;

            assign w_we = w_accept && (r_wr_ptr == BANK_W'(b));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_map  <= '0;
                    r_data <= '0;
                    r_cnt  <= '0;
                end else if (w_we) begin
                    r_map[w_base +: BUS_W]      <= bus.wr_sparsemap_i;
                    r_data[w_base + 1 +: BUS_W] <= bus.wr_nonzero_data_i;
                    r_cnt <= (r_beat_cnt == '0) ? CNT_W'(w_popcnt)
                                                : r_cnt + CNT_W'(w_popcnt);
                end
            end

            assign w_map[b]  = r_map;
            assign w_data[b] = r_data;
            assign w_cnt[b]  = r_cnt;
        end
    endgenerate

    assign bus.wr_ready_o        = w_wr_ready;
    assign bus.rd_valid_o        = (r_state[r_rd_ptr] == FULL);
    assign bus.rd_bank_o         = r_rd_ptr;
    assign bus.rd_sparsemap_o    = w_map[r_rd_ptr];
    assign bus.rd_nonzero_data_o = w_data[r_rd_ptr];
    assign bus.rd_nz_cnt_o       = w_cnt[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_sparse_chunk_pingpong_buf.sv
//============================================================================
// Module : tb_sparse_chunk_pingpong_buf
// Brief  : Directed self-checking bench with a chunk-queue reference model.
// Rev    : 1.0
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sparse_chunk_pingpong_buf;

    localparam int BUS_W = 128;
    localparam int MEM_W = 512;
    localparam int NB    = 2;
    localparam int DAT_W = 8;
    localparam int BEATS = MEM_W / BUS_W;
    localparam int WIDE  = MEM_W * DAT_W;

    typedef logic [BUS_W-1:0]            map_t;
    typedef logic [BUS_W-1:0][DAT_W-1:0] beat_t;
    typedef struct packed {
        logic [MEM_W-1:0]          map;
        logic [MEM_W:1][DAT_W-1:0] data;
        logic [31:0]               cnt;
    } chunk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sparse_chunk_pingpong_buf_if #(
        .BUS_W(BUS_W), .MEM_W(MEM_W), .NUM_BANKS(NB), .DAT_W(DAT_W)
    ) bus ();

    sparse_chunk_pingpong_buf #(
        .BUS_W(BUS_W), .MEM_W(MEM_W), .NUM_BANKS(NB), .DAT_W(DAT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [WIDE-1:0] act, input logic [WIDE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual[63:0]=%h required[63:0]=%h @%0t", nm, act[63:0], exp[63:0], $time);
        end
    endtask

    // Reference model: FIFO of completed chunks plus the chunk being assembled.
    chunk_t q[$];
    chunk_t part;
    int     part_beats = 0;
    int     head_bank  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            part_beats = 0;
            head_bank  = 0;
        end else if (bus.flush_i) begin
            q.delete();
            part_beats = 0;
            head_bank  = 0;
        end else begin
            bit acc, rel;
            acc = bus.wr_valid_i && (q.size() < NB);
            rel = bus.rd_release_i && (q.size() > 0);
            if (rel) begin
                q.delete(0);
                head_bank = (head_bank + 1) % NB;
            end
            if (acc) begin
                for (int j = 0; j < BUS_W; j++) begin
                    part.map[BUS_W*part_beats + j]      = bus.wr_sparsemap_i[j];
                    part.data[BUS_W*part_beats + 1 + j] = bus.wr_nonzero_data_i[j];
                end
                part_beats++;
                if (part_beats == BEATS) begin
                    part.cnt = $countones(part.map);
                    q.push_back(part);
                    part_beats = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("wr_ready", 64'(bus.wr_ready_o), 64'(q.size() < NB));
        chk("rd_valid", 64'(bus.rd_valid_o), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("rd_bank", 64'(bus.rd_bank_o), 64'(head_bank));
            chk("rd_nz_cnt", 64'(bus.rd_nz_cnt_o), 64'(q[0].cnt));
            chk_wide("rd_sparsemap", WIDE'(bus.rd_sparsemap_o), WIDE'(q[0].map));
            chk_wide("rd_data", bus.rd_nonzero_data_o, q[0].data);
        end
    end

    function automatic beat_t fill(input logic [7:0] v);
        beat_t d;
        for (int i = 0; i < BUS_W; i++) d[i] = v;
        return d;
    endfunction

    function automatic beat_t ramp(input logic [7:0] seed);
        beat_t d;
        for (int i = 0; i < BUS_W; i++) d[i] = seed ^ 8'(i);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input map_t m, input beat_t d);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        bus.wr_valid_i        = 1'b1;
        bus.wr_sparsemap_i    = m;
        bus.wr_nonzero_data_i = d;
        do begin
            @(negedge clk);
            acc = bus.wr_ready_o && !bus.flush_i;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_beat: actual=timeout required=accept @%0t", $time);
        end
        bus.wr_valid_i = 1'b0;
    endtask

    initial begin
        rst                   = 1'b1;
        bus.flush_i           = 1'b0;
        bus.wr_valid_i        = 1'b0;
        bus.wr_sparsemap_i    = '0;
        bus.wr_nonzero_data_i = '0;
        bus.rd_release_i      = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst wr_ready", 64'(bus.wr_ready_o), 64'd1);
        chk("rst rd_valid", 64'(bus.rd_valid_o), 64'd0);
        chk("rst nz_cnt",   64'(bus.rd_nz_cnt_o), 64'd0);
        chk("rst rd_bank",  64'(bus.rd_bank_o),   64'd0);

        // Full-density chunk of 8'hA5.
        for (int k = 0; k < BEATS; k++) begin
            if (k == BEATS - 1) chk("pre-final rd_valid", 64'(bus.rd_valid_o), 64'd0);
            send_beat('1, fill(8'hA5));
        end
        chk("full rd_valid", 64'(bus.rd_valid_o), 64'd1);
        chk("full nz_cnt",   64'(bus.rd_nz_cnt_o), 64'd512);
        chk("full rd_bank",  64'(bus.rd_bank_o),   64'd0);
        chk("full data[1]",  64'(bus.rd_nonzero_data_o[1]), 64'hA5);

        // Reset asserted between edges must clear outputs immediately.
        #2;
        rst = 1'b1;
        #1;
        chk("async rd_valid", 64'(bus.rd_valid_o),  64'd0);
        chk("async nz_cnt",   64'(bus.rd_nz_cnt_o), 64'd0);
        chk("async wr_ready", 64'(bus.wr_ready_o),  64'd1);
        chk("async map",      bus.rd_sparsemap_o[63:0], 64'd0);
        repeat (2) tick();
        rst = 1'b0;

        // Both banks full, ninth beat must wait for a release.
        for (int b = 0; b < 2 * BEATS; b++)
            send_beat({4{32'h0101_0101 << b}}, ramp(8'(b * 17)));
        chk("both full wr_ready", 64'(bus.wr_ready_o), 64'd0);
        chk("both full nz_cnt",   64'(bus.rd_nz_cnt_o), 64'd64);
        bus.wr_valid_i        = 1'b1;
        bus.wr_sparsemap_i    = map_t'(128'hF);
        bus.wr_nonzero_data_i = ramp(8'h3C);
        repeat (2) tick();
        chk("held wr_ready", 64'(bus.wr_ready_o), 64'd0);
        bus.rd_release_i = 1'b1;
        @(negedge clk);
        chk("release-cycle wr_ready", 64'(bus.wr_ready_o), 64'd0);
        tick();
        bus.rd_release_i = 1'b0;
        chk("after release rd_bank",  64'(bus.rd_bank_o),  64'd1);
        chk("after release wr_ready", 64'(bus.wr_ready_o), 64'd1);
        tick();
        bus.wr_valid_i = 1'b0;
        for (int k = 1; k < BEATS; k++) send_beat(map_t'(128'h3), ramp(8'(k + 8'h40)));
        bus.rd_release_i = 1'b1;
        tick();
        bus.rd_release_i = 1'b0;
        chk("held chunk rd_bank", 64'(bus.rd_bank_o),   64'd0);
        chk("held chunk nz_cnt",  64'(bus.rd_nz_cnt_o), 64'd10);

        // Mixed-density beats.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_beat(map_t'(128'h1), ramp(8'h11));
        send_beat(map_t'(128'h3), ramp(8'h22));
        send_beat(map_t'(128'h0), ramp(8'h33));
        send_beat('1,             ramp(8'h44));
        chk("mixed nz_cnt", 64'(bus.rd_nz_cnt_o), 64'd131);
        chk("map[0]",   64'(bus.rd_sparsemap_o[0]),   64'd1);
        chk("map[128]", 64'(bus.rd_sparsemap_o[128]), 64'd1);
        chk("map[129]", 64'(bus.rd_sparsemap_o[129]), 64'd1);
        chk("map[256]", 64'(bus.rd_sparsemap_o[256]), 64'd0);

        // Release of bank 0 together with the final beat into bank 1.
        for (int k = 0; k < BEATS - 1; k++) send_beat(map_t'(128'h1), ramp(8'(8'h50 + k)));
        bus.wr_valid_i        = 1'b1;
        bus.wr_sparsemap_i    = map_t'(128'h1);
        bus.wr_nonzero_data_i = ramp(8'h5F);
        bus.rd_release_i      = 1'b1;
        tick();
        bus.wr_valid_i   = 1'b0;
        bus.rd_release_i = 1'b0;
        chk("swap rd_valid", 64'(bus.rd_valid_o),  64'd1);
        chk("swap rd_bank",  64'(bus.rd_bank_o),   64'd1);
        chk("swap wr_ready", 64'(bus.wr_ready_o),  64'd1);
        chk("swap nz_cnt",   64'(bus.rd_nz_cnt_o), 64'd4);

        // Flush with a partial chunk in bank 0 and bank 1 full.
        send_beat(map_t'(128'hFF), ramp(8'h60));
        send_beat(map_t'(128'hFF), ramp(8'h61));
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("flush rd_valid", 64'(bus.rd_valid_o), 64'd0);
        chk("flush wr_ready", 64'(bus.wr_ready_o), 64'd1);
        chk("flush rd_bank",  64'(bus.rd_bank_o),  64'd0);
        for (int k = 0; k < BEATS; k++) send_beat(map_t'(128'hFF), ramp(8'(8'h70 + k)));
        chk("post-flush rd_valid", 64'(bus.rd_valid_o),  64'd1);
        chk("post-flush rd_bank",  64'(bus.rd_bank_o),   64'd0);
        chk("post-flush nz_cnt",   64'(bus.rd_nz_cnt_o), 64'd32);
        bus.rd_release_i = 1'b1;
        tick();
        chk("drained rd_valid", 64'(bus.rd_valid_o), 64'd0);
        tick();
        bus.rd_release_i = 1'b0;
        chk("idle release rd_bank", 64'(bus.rd_bank_o), 64'd1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
